// File: rtl/multi_timer_if.sv
// multi_timer_if: per-channel control and status bundle for multi_timer.
//   master : drives en, clr, tc, mode; observes count, busy, timeout, timeout_pulse
//   slave  : the timer itself
//   en, clr, mode, busy, timeout, timeout_pulse : one bit per channel
//   tc, count : WIDTH bits per channel, channel i at [i*WIDTH +: WIDTH]
interface multi_timer_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned WIDTH  = 4
);
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH-1:0]       clr;
  logic [NUM_CH*WIDTH-1:0] tc;
  logic [NUM_CH-1:0]       mode;
  logic [NUM_CH*WIDTH-1:0] count;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       timeout;
  logic [NUM_CH-1:0]       timeout_pulse;

  modport master (
    output en, clr, tc, mode,
    input  count, busy, timeout, timeout_pulse
  );

  modport slave (
    input  en, clr, tc, mode,
    output count, busy, timeout, timeout_pulse
  );
endinterface

// File: rtl/multi_timer.sv
// multi_timer: NUM_CH independent timeout channels, each IDLE -> RUN -> DONE.
//   clk   : system clock, all state on posedge
//   rst_n : asynchronous active-low reset, every channel to IDLE
//   bus   : multi_timer_if slave modport
//     en[i]    count enable          clr[i]  synchronous clear (beats en)
//     tc[i]    terminal count        mode[i] 0 one-shot, 1 periodic
//     count[i] registered count      busy[i] channel in RUN
//     timeout[i] one-shot in DONE    timeout_pulse[i] one cycle at terminal count
module multi_timer #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned WIDTH  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  multi_timer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           st_q, st_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] tc_q, tc_d;
    logic             mode_q, mode_d;
    logic             pulse_q, pulse_d;
    logic [WIDTH-1:0] tc_in;
    logic [WIDTH-1:0] cnt_inc;
    logic             hit;
    logic             term_mode;

    assign tc_in   = bus.tc[i*WIDTH +: WIDTH];
    assign cnt_inc = cnt_q + ONE;

    always_comb begin
      st_d      = st_q;
      cnt_d     = cnt_q;
      tc_d      = tc_q;
      mode_d    = mode_q;
      pulse_d   = 1'b0;
      hit       = 1'b0;
      term_mode = mode_q;
      if (bus.clr[i]) begin
        st_d  = S_IDLE;
        cnt_d = '0;
      end else begin
        case (st_q)
          S_IDLE: begin
            if (bus.en[i] && (tc_in != '0)) begin
              tc_d      = tc_in;
              mode_d    = bus.mode[i];
              term_mode = bus.mode[i];
              if (tc_in == ONE) begin
                hit = 1'b1;
              end else begin
                st_d  = S_RUN;
                cnt_d = ONE;
              end
            end
          end
          S_RUN: begin
            if (bus.en[i]) begin
              if (cnt_inc == tc_q) hit = 1'b1;
              else                 cnt_d = cnt_inc;
            end
          end
          default: ;  // DONE holds until clr or reset
        endcase

        // Terminal action shared by the IDLE (tc==1) and RUN entries; tc_d
        // already holds the terminal count that applies in either case.
        if (hit) begin
          pulse_d = 1'b1;
          if (!term_mode) begin
            st_d  = S_DONE;
            cnt_d = tc_d;
          end else begin
            st_d   = S_RUN;
            cnt_d  = '0;
            tc_d   = tc_in;
            mode_d = bus.mode[i];
            // A reserved tc of 0 picked up at the wrap parks the channel in
            // IDLE rather than letting it count through the full range.
            if (tc_in == '0) st_d = S_IDLE;
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q    <= S_IDLE;
        cnt_q   <= '0;
        tc_q    <= '0;
        mode_q  <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        st_q    <= st_d;
        cnt_q   <= cnt_d;
        tc_q    <= tc_d;
        mode_q  <= mode_d;
        pulse_q <= pulse_d;
      end
    end

    assign bus.count[i*WIDTH +: WIDTH] = cnt_q;
    assign bus.busy[i]                 = (st_q == S_RUN);
    assign bus.timeout[i]              = (st_q == S_DONE);
    assign bus.timeout_pulse[i]        = pulse_q;
  end

endmodule
